// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder (optional subtractor, SERIAL_ADDER_SUB_EN) with an IDLE/RUN/DONE controller, LSB first.
// Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH; next accept no earlier than k+WIDTH+2.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    // Counter only has to reach WIDTH-1; the final increment may wrap but the FSM has left RUN by then.
    localparam int CW = $clog2(WIDTH);
    // The result register holds the low WIDTH-1 sum bits; the MSB is taken straight from the adder on the last edge.
    localparam int RW = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [RW-1:0]    r_sh;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;

    logic [WIDTH-1:0] b_load;
    logic             c_init;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             s;
    logic             cout;

    // Operand conditioning: subtraction is A + ~B + 1, so invert B and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~B : B;
    assign c_init = sub;
`else
    assign b_load = B;
    assign c_init = 1'b0;
`endif

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // One full-add stage: two half adders plus an OR for the carry.
    assign ha1_s = a_sh[0] ^ b_sh[0];
    assign ha1_c = a_sh[0] & b_sh[0];
    assign ha2_s = ha1_s ^ c;
    assign ha2_c = ha1_s & c;
    assign s     = ha2_s;
    assign cout  = ha1_c | ha2_c;

    // State register; reset drops straight back to IDLE, aborting any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DONE lasts exactly one cycle and never re-arms on its own.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded directly from the state so done/busy drop immediately on reset.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: load on accept, then one bit per RUN edge; Sum/Carry move only on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Carry <= 1'b0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= b_load;
            r_sh <= '0;
            c    <= c_init;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= RW'({s, r_sh} >> 1);
            c    <= cout;
            cnt  <= cnt + CW'(1);
            if (last) begin
                Sum   <= {s, r_sh};
                Carry <= cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         sub   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Carry;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Carry (Carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request occupies the block for WIDTH+1 edges after
    // acceptance; the last of those cycles is the done cycle, where the result appears.
    int           m_left = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_carry = 1'b0;
    logic [W-1:0] m_pend = '0;
    logic         m_pend_c = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  = 0;
            m_sum   = '0;
            m_carry = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left = W + 1;
                if (HAS_SUB && sub) begin
                    m_pend   = A - B;
                    m_pend_c = (A >= B);
                end else begin
                    {m_pend_c, m_pend} = {1'b0, A} + {1'b0, B};
                end
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_sum   = m_pend;
                m_carry = m_pend_c;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cyc_busy",  32'(busy),  32'(m_left > 0));
        check("cyc_done",  32'(done),  32'(m_left == 1));
        check("cyc_sum",   32'(Sum),   32'(m_sum));
        check("cyc_carry", 32'(Carry), 32'(m_carry));
    end

    // Runs one operation from an idle negedge; optionally hammers start/A/B while busy.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit junk, output logic [W-1:0] got_sum, output logic got_c);
        bit seen;
        int lat;
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        if (junk) begin
            start = 1'b1; A = '1; B = '1; sub = HAS_SUB;
        end else begin
            start = 1'b0; A = W'($urandom); B = W'($urandom);
        end
        seen = 1'b0;
        lat = 0;
        got_sum = '0;
        got_c = 1'b0;
        for (int i = 1; i <= W + 4 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat = i;
                got_sum = Sum;
                got_c = Carry;
                start = 1'b0;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(W));
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);
        check("single_done", 32'(done), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [W-1:0] gs;
        logic         gc;
        int           dq[$];
        int           ndone;
        bit           idle;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_sum",   32'(Sum),   32'd0);
        check("rst_carry", 32'(Carry), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed additions with hand-computed results
        do_op(8'h00, 8'h00, 1'b0, 1'b0, gs, gc);
        check("zero_sum", 32'(gs), 32'h00);
        check("zero_carry", 32'(gc), 32'd0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, gs, gc);
        check("ff01_sum", 32'(gs), 32'h00);
        check("ff01_carry", 32'(gc), 32'd1);
        do_op(8'hA5, 8'h5A, 1'b0, 1'b0, gs, gc);
        check("a55a_sum", 32'(gs), 32'hFF);
        check("a55a_carry", 32'(gc), 32'd0);

        // start/A/B activity during RUN must be ignored
        do_op(8'h12, 8'h34, 1'b0, 1'b1, gs, gc);
        check("ignore_sum", 32'(gs), 32'h46);
        check("ignore_carry", 32'(gc), 32'd0);
        @(negedge clk);
        check("no_second_op", 32'(busy), 32'd0);
        check("held_sum", 32'(Sum), 32'h46);

        // Reset in the middle of RUN aborts with no done
        A = 8'h80; B = 8'h80; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        check("abort_sum",   32'(Sum),   32'd0);
        check("abort_carry", 32'(Carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(8'h80, 8'h80, 1'b0, 1'b0, gs, gc);
        check("post_abort_sum", 32'(gs), 32'h00);
        check("post_abort_carry", 32'(gc), 32'd1);
        ndone = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_stray_done", 32'(ndone), 32'd0);

        // Back-to-back with start held high
        A = W'($urandom); B = W'($urandom); sub = 1'b0; start = 1'b1;
        for (int e = 1; e <= 4 * (W + 2); e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dq.push_back(e);
                A = W'($urandom);
                B = W'($urandom);
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(dq.size()), 32'd4);
        check("b2b_first", 32'(dq.size() > 0 ? dq[0] : 0), 32'(W + 1));
        for (int i = 1; i < dq.size(); i++)
            check("b2b_period", 32'(dq[i] - dq[i-1]), 32'(W + 2));
        idle = 1'b0;
        for (int i = 0; i < W + 4 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        check("b2b_idle", 32'(idle), 32'd1);

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h05, 8'h03, 1'b1, 1'b0, gs, gc);
        check("sub53_sum", 32'(gs), 32'h02);
        check("sub53_carry", 32'(gc), 32'd1);
        do_op(8'h03, 8'h05, 1'b1, 1'b0, gs, gc);
        check("sub35_sum", 32'(gs), 32'hFE);
        check("sub35_carry", 32'(gc), 32'd0);
`endif

        // Randomized operations, checked every cycle against the model
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(W'($urandom), W'($urandom), HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0,
                  1'($urandom_range(0, 1)), gs, gc);
            check("rand_sum", 32'(gs), 32'(m_sum));
            check("rand_carry", 32'(gc), 32'(m_carry));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 A  input  WIDTH  first operand; sampled only on the accepting edge.
REQ-006 B  input  WIDTH  second operand; sampled only on the accepting edge.
REQ-007 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 done  output  1  one-cycle pulse; result is valid from this cycle.
REQ-009 Sum  output  WIDTH  registered result.
REQ-010 Carry  output  1  registered carry-out of the MSB.

Function
REQ-011 The block SHALL add A and B bit-serially, LSB first, one bit per clock, using a single 1-bit full-add stage built from two half-add stages plus an OR: s = a^b^c, c' = (a&b)|((a^b)&c).
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE -> RUN on an edge with start=1: load A and B into internal shift registers, clear the internal carry, clear the bit counter.
REQ-014 In RUN, each edge SHALL process bit 0 of the shift registers, shift both right, shift s into the MSB of the result shift register, update the carry and increment the counter.
REQ-015 RUN -> DONE on the edge that processes bit WIDTH-1; that same edge SHALL load Sum from the completed result and Carry from c'.
REQ-016 DONE -> IDLE unconditionally on the next edge.
REQ-017 done SHALL equal (state==DONE), giving exactly one cycle high per operation.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, with Sum and Carry valid from that cycle.
REQ-019 busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-020 Sum and Carry SHALL hold their last values until the next completion; they SHALL NOT change during RUN.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; a new start is accepted only in IDLE.
REQ-022 Changes on A and B after the accepting edge SHALL NOT affect the running operation.
REQ-023 The bit counter SHALL be wide enough for WIDTH; it SHALL NOT wrap before reaching WIDTH-1.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, Sum=0 and Carry=0, and clear the counter, shift registers and internal carry.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a start on the first edge.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN SHALL control subtraction support.
REQ-027 With SERIAL_ADDER_SUB_EN defined, the block SHALL add a 1-bit input port sub, sampled with A and B.
REQ-028 With sub=1, the block SHALL load ~B and initialise the carry to 1, so that Sum = A-B mod 2^WIDTH and Carry = 1 means no borrow.
REQ-029 With sub=0, or without the macro, the block SHALL perform plain addition and the sub port SHALL NOT exist.

Verification (WIDTH=8)
REQ-030 Reset, then A=0x00, B=0x00, start pulse at edge k -> busy high from k, done high only after edge k+8, Sum=0x00, Carry=0.
REQ-031 A=0xFF, B=0x01 -> Sum=0x00, Carry=1; A=0xA5, B=0x5A -> Sum=0xFF, Carry=0.
REQ-032 Start accepted with A=0x12, B=0x34; during RUN drive start=1, A=0xFF and B=0xFF -> exactly one done, Sum=0x46, Carry=0, and no second operation starts.
REQ-033 Complete an op giving Sum=0x46; start A=0x80, B=0x80; assert rst at the 4th RUN edge -> outputs are 0 immediately and there is no done; then start 0x80+0x80 -> Sum=0x00, Carry=1.
REQ-034 Back-to-back: start held high continuously -> operations complete every WIDTH+2 cycles with a single done pulse each.
REQ-035 With SERIAL_ADDER_SUB_EN: sub=1, A=0x05, B=0x03 -> Sum=0x02, Carry=1; sub=1, A=0x03, B=0x05 -> Sum=0xFE, Carry=0.
